// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into APB transfers
// (IDLE, SETUP, ACCESS), returns one response per command, and aborts any
// transfer whose slave holds pready low for too long.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  // A disabled watchdog still gets a 1-bit counter so no vector is zero wide.
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    WDOG_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]  pstrb_q, pstrb_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  assign cmd_ready   = (state_q == IDLE) && presetn;
  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  // Next-state logic: accept in IDLE, one SETUP cycle, then ACCESS until
  // pready or the watchdog ends the transfer and emits a response.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer silently.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven and randomized checks of the APB
// bridge against a latency/response model, plus hand-written corner cases.
module tb_apb_master_bridge;

  localparam int TMO = 4;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        slvErr;
    logic [31:0] prdata;
    int          expLat;
    int          expEn;
    logic [31:0] expRdata;
    logic        expErr;
    logic        expTo;
  } vec_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_valid0, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [31:0] prdata;
  logic        pready, pready0, pslverr;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, pwdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [3:0]  pstrb;

  logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic [31:0] rsp_rdata0, pwdata0;
  logic        psel0, penable0, pwrite0;
  logic [7:0]  paddr0;
  logic [3:0]  pstrb0;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0), .pwdata(pwdata0),
    .pstrb(pstrb0), .prdata(prdata), .pready(pready0), .pslverr(pslverr)
  );

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drive the command-side inputs.
  task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  function automatic vec_t mkVec(input logic w, input logic [7:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int waits, input logic e,
                                 input logic [31:0] rd, input int lat, input int en,
                                 input logic [31:0] xr, input logic xe, input logic xt);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.strb = s; v.waits = waits;
    v.slvErr = e; v.prdata = rd; v.expLat = lat; v.expEn = en;
    v.expRdata = xr; v.expErr = xe; v.expTo = xt;
    return v;
  endfunction

  // Reference model: a transfer whose slave waits at least TMO ACCESS cycles
  // is cut off by the watchdog; otherwise it completes after waits+1 ACCESS.
  function automatic vec_t model(input vec_t vin);
    vec_t v = vin;
    if (TMO != 0 && v.waits >= TMO) begin
      v.expLat = 2 + TMO; v.expEn = TMO; v.expRdata = 32'h0; v.expErr = 1'b1; v.expTo = 1'b1;
    end else begin
      v.expLat = 3 + v.waits; v.expEn = v.waits + 1;
      v.expRdata = v.write ? 32'h0 : v.prdata; v.expErr = v.slvErr; v.expTo = 1'b0;
    end
    return v;
  endfunction

  // Run one command through the bridge acting as a slave that holds pready
  // low for v.waits ACCESS cycles, then compare everything observed.
  task automatic runTransfer(input vec_t v, input string tag);
    int lat = 0, selCycles = 0, enCycles = 0, accessSeen = 0;
    logic done = 1'b0, stable = 1'b1;
    logic [31:0] rd = '0;
    logic er = 1'b0, to = 1'b0;
    @(negedge pclk);
    applyStimulus(1'b1, v.write, v.addr, v.wdata, v.strb);
    prdata = v.prdata; pslverr = v.slvErr; pready = 1'b0;
    checkOutput({tag, "_ready"}, cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; to = rsp_timeout; done = 1'b1;
      end else begin
        if (psel) selCycles++;
        if (penable) begin
          enCycles++; accessSeen++;
          pready = (accessSeen > v.waits);
        end else begin
          pready = 1'b0;
        end
        if (psel && (paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata ||
                     pstrb !== (v.write ? v.strb : 4'h0)))
          stable = 1'b0;
        @(negedge pclk);
      end
    end
    pready = 1'b0;
    checkOutput({tag, "_gotrsp"}, done, 1);
    checkOutput({tag, "_lat"}, lat, v.expLat);
    checkOutput({tag, "_psel"}, selCycles, v.expEn + 1);
    checkOutput({tag, "_penable"}, enCycles, v.expEn);
    checkOutput({tag, "_stable"}, stable, 1);
    checkOutput({tag, "_rdata"}, rd, v.expRdata);
    checkOutput({tag, "_err"}, er, v.expErr);
    checkOutput({tag, "_tmo"}, to, v.expTo);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_time_limit actual=expired expected=finished");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   acc[3];
    int   na;
    logic accepted;
    logic [11:0] rspMask;
    int   n;

    presetn = 1'b0; cmd_valid0 = 1'b0; pready = 1'b0; pready0 = 1'b0;
    pslverr = 1'b0; prdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

    // Reset state.
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_psel", psel, 0);
    checkOutput("rst_penable", penable, 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    presetn = 1'b1;
    #1;
    checkOutput("rst_release_ready", cmd_ready, 1);

    // Hand-derived vectors for the named scenarios (watchdog at 4 cycles).
    tbl.push_back(mkVec(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'hAAAA5555, 3, 1, 32'h0, 0, 0));
    tbl.push_back(mkVec(0, 8'h04, 32'h0BADF00D, 4'hF, 2, 0, 32'h12345678, 5, 3, 32'h12345678, 0, 0));
    tbl.push_back(mkVec(1, 8'hFF, 32'h00000001, 4'h3, 0, 1, 32'h0, 3, 1, 32'h0, 1, 0));
    tbl.push_back(mkVec(0, 8'h20, 32'h55AA55AA, 4'hF, 20, 1, 32'hFFFFFFFF, 6, 4, 32'h0, 1, 1));
    tbl.push_back(mkVec(0, 8'h44, 32'h0, 4'h0, 3, 1, 32'hC0FFEE00, 6, 4, 32'hC0FFEE00, 1, 0));
    tbl.push_back(mkVec(1, 8'h81, 32'h01020304, 4'h5, 1, 0, 32'h77777777, 4, 2, 32'h0, 0, 0));
    for (int i = 0; i < tbl.size(); i++)
      runTransfer(tbl[i], $sformatf("vec%0d", i));

    // Randomized transfers checked against the reference model.
    for (int i = 0; i < 16; i++) begin
      v = mkVec($urandom_range(0, 1), 8'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, 6), $urandom_range(0, 1), $urandom, 0, 0, 0, 0, 0);
      runTransfer(model(v), $sformatf("rnd%0d", i));
    end

    // Back-to-back commands with cmd_valid held and a zero-wait slave.
    @(negedge pclk);
    applyStimulus(1'b1, 1'b1, 8'h30, 32'hA5A5A5A5, 4'hF);
    pready = 1'b1; pslverr = 1'b0;
    na = 0; rspMask = '0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid) rspMask[c] = 1'b1;
      accepted = 1'b0;
      if (cmd_valid && cmd_ready && na < 3) begin
        acc[na] = c; na++; accepted = 1'b1;
      end
      @(negedge pclk);
      if (accepted) begin
        if (na == 3) cmd_valid = 1'b0;
        else cmd_addr = cmd_addr + 8'h04;
      end
    end
    pready = 1'b0;
    checkOutput("b2b_count", na, 3);
    checkOutput("b2b_acc0", acc[0], 0);
    checkOutput("b2b_acc1", acc[1], 3);
    checkOutput("b2b_acc2", acc[2], 6);
    checkOutput("b2b_rsp_cycles", rspMask, 12'h248);

    // Reset asserted for one cycle while a read is wait-stated in ACCESS.
    @(negedge pclk);
    applyStimulus(1'b1, 1'b0, 8'h5A, 32'hCAFEF00D, 4'hF);
    pready = 1'b0; prdata = 32'h11112222;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    checkOutput("mid_in_access", penable, 1);
    presetn = 1'b0;
    @(negedge pclk);
    checkOutput("mid_psel", psel, 0);
    checkOutput("mid_penable", penable, 0);
    checkOutput("mid_pwrite", pwrite, 0);
    checkOutput("mid_paddr", paddr, 0);
    checkOutput("mid_pwdata", pwdata, 0);
    checkOutput("mid_pstrb", pstrb, 0);
    checkOutput("mid_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rsp_rdata", rsp_rdata, 0);
    checkOutput("mid_rsp_err", rsp_err, 0);
    checkOutput("mid_rsp_tmo", rsp_timeout, 0);
    checkOutput("mid_cmd_ready_low", cmd_ready, 0);
    presetn = 1'b1;
    pready = 1'b1;
    #1;
    checkOutput("mid_cmd_ready_high", cmd_ready, 1);
    n = 0;
    repeat (6) begin
      @(negedge pclk);
      if (rsp_valid) n++;
    end
    pready = 1'b0;
    checkOutput("mid_no_rsp", n, 0);

    // Watchdog disabled: a slave that never answers keeps the bridge in ACCESS.
    @(negedge pclk);
    cmd_write = 1'b0; cmd_addr = 8'h66; cmd_valid0 = 1'b1;
    checkOutput("nowd_ready", cmd_ready0, 1);
    @(negedge pclk);
    cmd_valid0 = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge pclk);
      if (rsp_valid0) n++;
    end
    checkOutput("nowd_no_rsp", n, 0);
    checkOutput("nowd_penable", penable0, 1);
    checkOutput("nowd_psel", psel0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

- Converts a simple valid/ready command interface into APB transfers (IDLE, SETUP, ACCESS) and returns one response per command.
- Sits directly upstream of the APB memory slave. It is the bus driver whose outputs the APB protocol assertions check:
  - address and write data are stable for the whole transfer;
  - pslverr is sampled only when psel, penable and pready are all high.
- Adds a wait-state watchdog so a hung slave cannot stall the command source forever.

## Interface

Parameters:
- ADDR_WIDTH, default 8: APB and command address width.
- DATA_WIDTH, default 32: data width; must be a multiple of 8.
- TIMEOUT_CYCLES, default 16: maximum ACCESS cycles per transfer. 0 disables the watchdog.

Ports:
- pclk  in  1  clock; all logic on its rising edge.
- presetn  in  1  reset: synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer ended by the watchdog.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.

## Operation

States:
- IDLE:
  - psel = 0, penable = 0.
  - cmd_ready = 1 only in IDLE, and only while presetn = 1.
  - cmd_valid && cmd_ready at a clock edge captures cmd_* into the APB output registers, then goes to SETUP.
- SETUP:
  - psel = 1, penable = 0.
  - Watchdog counter cleared.
  - Always goes to ACCESS after exactly one cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - pready = 1 at the edge: complete the transfer.
    - rsp_rdata = read ? prdata : 0.
    - rsp_err = pslverr, rsp_timeout = 0.
    - Go to IDLE.
  - pready = 0 and TIMEOUT_CYCLES ≠ 0 and counter == TIMEOUT_CYCLES-1: abort.
    - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - Go to IDLE.
  - Otherwise: counter increments and the bridge stays in ACCESS.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.

Data path rules:
- paddr, pwrite, pwdata and pstrb are registered. They change only when a command is accepted and hold from SETUP through the last ACCESS cycle.
- In IDLE they keep their last value.
- pstrb is forced to 0 for reads. pwdata keeps cmd_wdata for reads; the slave ignores it.
- pslverr and prdata are ignored outside ACCESS && pready.
- There is no command buffering. cmd_valid while cmd_ready = 0 is held by the source; the bridge does not register it.

## Timing

- Reset (presetn = 0 at an edge), regardless of state:
  - Next cycle: IDLE, psel = penable = pwrite = 0, paddr = pwdata = pstrb = 0, rsp_valid = rsp_err = rsp_timeout = 0, rsp_rdata = 0, counter = 0.
  - cmd_ready = 0 while presetn = 0.
- Reset mid-transfer: the transfer is abandoned and no response is produced. psel drops the cycle after the reset edge.
- Command accepted at edge E0:
  - Cycle after E0: SETUP.
  - Next cycle: ACCESS.
  - Zero wait states: pready = 1 in that first ACCESS cycle, sampled at edge E2.
  - After E2: rsp_valid = 1 for exactly one cycle, state IDLE, psel = 0.
- Latency from accept to rsp_valid:
  - 3 cycles, plus 1 per ACCESS cycle with pready = 0.
  - Timeout case: 2 + TIMEOUT_CYCLES.
- Back-to-back: the next command can be accepted in the same cycle that rsp_valid is high. Minimum period is 3 cycles per transfer.
- rsp_rdata, rsp_err and rsp_timeout hold their values until the next response; they are valid only with rsp_valid.

## Test plan

- Zero-wait write:
  - Stimulus: cmd_write = 1, addr 0x10, wdata 0xDEADBEEF, strb 0xF; pready tied 1.
  - Required: psel high 2 cycles, penable high 1; rsp_valid 3 cycles after accept; rsp_err = 0, rsp_rdata = 0.
- Read with 2 wait states:
  - Stimulus: read addr 0x04; pready low for 2 ACCESS cycles, then high with prdata 0x12345678.
  - Required: paddr stable throughout; pstrb = 0; rsp_valid 5 cycles after accept; rsp_rdata = 0x12345678.
- Slave error:
  - Stimulus: write addr 0xFF; slave returns pready = 1, pslverr = 1.
  - Required: rsp_err = 1, rsp_timeout = 0.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES = 4; pready held 0.
  - Required: ACCESS lasts exactly 4 cycles; psel drops; rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0 at accept + 6.
  - With TIMEOUT_CYCLES = 0 and pready held 0 for 100 cycles: no response, bridge stays in ACCESS.
- Reset mid-ACCESS:
  - Stimulus: presetn = 0 for 1 cycle during a wait-stated read.
  - Required: all outputs at reset values next cycle; no rsp_valid; cmd_ready = 1 once presetn = 1.
- Back-to-back:
  - Stimulus: 3 commands presented continuously.
  - Required: accepts at cycles 0, 3 and 6; each rsp_valid coincides with the next accept.
